// File: rtl/mem_access_seq_if.sv
// mem_access_seq_if
// Bundles the request handshake, the word-aligned memory port and the
// completion/result signals of the load/store sequencer.
//   master : sequencer view (takes requests, drives the memory port)
//   slave  : environment view (control FSM + memory)
// Signals:
//   req_valid/req_ready/req_write/req_funct3/req_addr/req_wdata : request
//   mem_addr/mem_read/mem_write/mem_byte_enable/mem_wdata        : beat out
//   mem_rdata/mem_resp                                           : beat in
//   done/rdata/fault/fault_cause                                 : result
interface mem_access_seq_if #(
  parameter int XLEN = 32
);
  localparam int B = XLEN / 8;

  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic [XLEN-1:0] mem_addr;
  logic            mem_read;
  logic            mem_write;
  logic [B-1:0]    mem_byte_enable;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_resp;
  logic            done;
  logic [XLEN-1:0] rdata;
  logic            fault;
  logic [1:0]      fault_cause;

  modport master (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata,
           mem_rdata, mem_resp,
    output req_ready, mem_addr, mem_read, mem_write, mem_byte_enable,
           mem_wdata, done, rdata, fault, fault_cause
  );

  modport slave (
    output req_valid, req_write, req_funct3, req_addr, req_wdata,
           mem_rdata, mem_resp,
    input  req_ready, mem_addr, mem_read, mem_write, mem_byte_enable,
           mem_wdata, done, rdata, fault, fault_cause
  );
endinterface

// File: rtl/mem_access_seq.sv
// mem_access_seq
// Load/store sequencer for the multicycle RV32I/RV64I datapath. Takes one
// request, issues one or two word-aligned beats (two when the access crosses
// a word boundary), extends load data and reports faults for illegal funct3,
// disallowed misalignment and beat timeout.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : mem_access_seq_if.master (request, memory port, result)
module mem_access_seq #(
  parameter int XLEN             = 32,
  parameter int TIMEOUT          = 255,
  parameter int ALLOW_MISALIGNED = 1
) (
  input  logic                clk,
  input  logic                rst,
  mem_access_seq_if.master    bus
);
  localparam int B     = XLEN / 8;
  localparam int OFF_W = $clog2(B);
  localparam int MW    = 2 * B;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        cause;
  logic [XLEN-1:0]   rdata_p2;

  logic              write_p0;
  logic [2:0]        f3_p0;
  logic [XLEN-1:0]   addr_p0;
  logic [XLEN-1:0]   wdata_p0;
  logic [XLEN-1:0]   lo_p1;

  logic              accept, req_legal, req_cross, cross_p0;
  logic              in_beat, timeout_hit;
  logic [3:0]        req_size, size_p0;
  logic [OFF_W-1:0]  req_off, off_p0;
  logic [MW-1:0]     mask_p0;
  logic [XLEN-1:0]   base_addr, lo_src;

  function automatic logic [3:0] size_of(input logic [2:0] f3);
    return 4'd1 << f3[1:0];
  endfunction

  function automatic logic f3_legal(input logic wr, input logic [2:0] f3);
    case (f3)
      3'b000, 3'b001, 3'b010: return 1'b1;
      3'b011:                 return (XLEN == 64);
      3'b100, 3'b101:         return !wr;
      3'b110:                 return !wr && (XLEN == 64);
      default:                return 1'b0;
    endcase
  endfunction

  function automatic logic crosses(input logic [OFF_W-1:0] off, input logic [3:0] size);
    return (int'(off) + int'(size)) > B;
  endfunction

  // {hi, lo} is shifted down so the addressed byte lands in lane 0.
  function automatic logic [XLEN-1:0] load_extend(input logic [2*XLEN-1:0] pair,
                                                  input logic [OFF_W-1:0]  off,
                                                  input logic [2:0]        f3);
    logic [2*XLEN-1:0] sh;
    logic [XLEN-1:0]   w;
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    logic signed [31:0] w_s;
    sh  = pair >> {off, 3'b000};
    w   = sh[XLEN-1:0];
    b_s = w[7:0];
    h_s = w[15:0];
    w_s = w[31:0];
    case (f3)
      3'b000:  load_extend = XLEN'(b_s);
      3'b001:  load_extend = XLEN'(h_s);
      3'b010:  load_extend = XLEN'(w_s);
      3'b100:  load_extend = XLEN'(w[7:0]);
      3'b101:  load_extend = XLEN'(w[15:0]);
      3'b110:  load_extend = XLEN'(w[31:0]);
      default: load_extend = w;
    endcase
  endfunction

  always_comb begin
    accept      = (state == IDLE) && bus.req_valid;
    req_size    = size_of(bus.req_funct3);
    req_off     = bus.req_addr[OFF_W-1:0];
    req_legal   = f3_legal(bus.req_write, bus.req_funct3);
    req_cross   = crosses(req_off, req_size);
    size_p0     = size_of(f3_p0);
    off_p0      = addr_p0[OFF_W-1:0];
    cross_p0    = crosses(off_p0, size_p0);
    mask_p0     = (MW'(1) << size_p0) - MW'(1);
    base_addr   = {addr_p0[XLEN-1:OFF_W], {OFF_W{1'b0}}};
    in_beat     = (state == BEAT0) || (state == BEAT1);
    // A response arriving in the final count cycle wins over the timeout.
    timeout_hit = (TIMEOUT > 0) && in_beat && !bus.mem_resp && (cnt == CNT_LAST);
    lo_src      = (state == BEAT0) ? bus.mem_rdata : lo_p1;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!req_legal || (req_cross && (ALLOW_MISALIGNED == 0))) state_nx = RESP;
          else                                                       state_nx = BEAT0;
        end
      end
      BEAT0: begin
        if (bus.mem_resp)     state_nx = cross_p0 ? BEAT1 : RESP;
        else if (timeout_hit) state_nx = RESP;
      end
      BEAT1: begin
        if (bus.mem_resp || timeout_hit) state_nx = RESP;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Memory port is purely a function of state, so reset drops it at once.
  always_comb begin
    bus.req_ready       = (state == IDLE);
    bus.mem_read        = in_beat && !write_p0;
    bus.mem_write       = in_beat && write_p0;
    bus.mem_addr        = '0;
    bus.mem_byte_enable = '0;
    bus.mem_wdata       = '0;
    case (state)
      BEAT0: begin
        bus.mem_addr        = base_addr;
        bus.mem_byte_enable = B'(mask_p0 << off_p0);
        bus.mem_wdata       = wdata_p0 << {off_p0, 3'b000};
      end
      BEAT1: begin
        bus.mem_addr        = base_addr + XLEN'(B);
        bus.mem_byte_enable = B'(mask_p0 >> (B - int'(off_p0)));
        bus.mem_wdata       = wdata_p0 >> (8 * (B - int'(off_p0)));
      end
      default: ;
    endcase
    bus.done        = (state == RESP);
    bus.fault       = (state == RESP) && (cause != 2'd0);
    bus.fault_cause = cause;
    bus.rdata       = rdata_p2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      cause    <= 2'd0;
      rdata_p2 <= '0;
    end else begin
      state <= state_nx;
      if ((state_nx == BEAT0 || state_nx == BEAT1) && (state_nx != state))
        cnt <= '0;
      else if (in_beat && !bus.mem_resp)
        cnt <= cnt + CNT_W'(1);

      if (accept) begin
        rdata_p2 <= '0;
        if (!req_legal)                                     cause <= 2'd3;
        else if (req_cross && (ALLOW_MISALIGNED == 0))      cause <= 2'd1;
        else                                                cause <= 2'd0;
      end else if (timeout_hit) begin
        cause <= 2'd2;
      end

      if (in_beat && bus.mem_resp && (state_nx == RESP) && !write_p0)
        rdata_p2 <= load_extend({bus.mem_rdata, lo_src}, off_p0, f3_p0);
    end
  end

  // Stage p0: request latch; stage p1: low beat read data.
  always_ff @(posedge clk) begin
    if (accept) begin
      write_p0 <= bus.req_write;
      f3_p0    <= bus.req_funct3;
      addr_p0  <= bus.req_addr;
      wdata_p0 <= bus.req_wdata;
    end
    if ((state == BEAT0) && bus.mem_resp)
      lo_p1 <= bus.mem_rdata;
  end
endmodule

// File: tb/tb_mem_access_seq.sv
module tb_mem_access_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [31:0] mem_rdata = '0;
  logic        mem_resp = 1'b0;

  mem_access_seq_if #(.XLEN(32)) if_a ();
  mem_access_seq_if #(.XLEN(32)) if_b ();

  assign if_a.req_valid  = req_valid && !sel;
  assign if_a.req_write  = req_write;
  assign if_a.req_funct3 = req_funct3;
  assign if_a.req_addr   = req_addr;
  assign if_a.req_wdata  = req_wdata;
  assign if_a.mem_rdata  = mem_rdata;
  assign if_a.mem_resp   = mem_resp;
  assign if_b.req_valid  = req_valid && sel;
  assign if_b.req_write  = req_write;
  assign if_b.req_funct3 = req_funct3;
  assign if_b.req_addr   = req_addr;
  assign if_b.req_wdata  = req_wdata;
  assign if_b.mem_rdata  = mem_rdata;
  assign if_b.mem_resp   = mem_resp;

  mem_access_seq #(.XLEN(32), .TIMEOUT(4), .ALLOW_MISALIGNED(1)) u_a (.clk(clk), .rst(rst), .bus(if_a));
  mem_access_seq #(.XLEN(32), .TIMEOUT(4), .ALLOW_MISALIGNED(0)) u_b (.clk(clk), .rst(rst), .bus(if_b));

  logic        o_ready, o_rd, o_wr, o_done, o_fault;
  logic [31:0] o_addr, o_wdata, o_rdata;
  logic [3:0]  o_be;
  logic [1:0]  o_cause;
  assign o_ready = sel ? if_b.req_ready       : if_a.req_ready;
  assign o_rd    = sel ? if_b.mem_read        : if_a.mem_read;
  assign o_wr    = sel ? if_b.mem_write       : if_a.mem_write;
  assign o_addr  = sel ? if_b.mem_addr        : if_a.mem_addr;
  assign o_be    = sel ? if_b.mem_byte_enable : if_a.mem_byte_enable;
  assign o_wdata = sel ? if_b.mem_wdata       : if_a.mem_wdata;
  assign o_done  = sel ? if_b.done            : if_a.done;
  assign o_rdata = sel ? if_b.rdata           : if_a.rdata;
  assign o_fault = sel ? if_b.fault           : if_a.fault;
  assign o_cause = sel ? if_b.fault_cause     : if_a.fault_cause;

  typedef struct {
    bit          sel;
    bit          wr;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, lo, hi;
    int          beats;
    logic [31:0] a0;
    logic [3:0]  be0;
    logic [31:0] wd0, a1;
    logic [3:0]  be1;
    logic [31:0] wd1, rdata;
    logic        fault;
    logic [1:0]  cause;
    int          lat;
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit s, bit w, logic [2:0] f, logic [31:0] ad, logic [31:0] wd,
                              logic [31:0] lo, logic [31:0] hi, int nb,
                              logic [31:0] a0, logic [3:0] be0, logic [31:0] wd0,
                              logic [31:0] a1, logic [3:0] be1, logic [31:0] wd1,
                              logic [31:0] rd, logic fl, logic [1:0] c, int lat);
    vec_t v;
    v.sel = s; v.wr = w; v.f3 = f; v.addr = ad; v.wdata = wd; v.lo = lo; v.hi = hi;
    v.beats = nb; v.a0 = a0; v.be0 = be0; v.wd0 = wd0; v.a1 = a1; v.be1 = be1; v.wd1 = wd1;
    v.rdata = rd; v.fault = fl; v.cause = c; v.lat = lat;
    return v;
  endfunction

  task automatic issue(input bit s, input bit w, input logic [2:0] f, input logic [31:0] ad,
                       input logic [31:0] wd, input string tag);
    @(negedge clk);
    sel = s; req_write = w; req_funct3 = f; req_addr = ad; req_wdata = wd;
    check($sformatf("%s_ready", tag), o_ready, 1'b1);
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Immediate-response transaction: mem_resp held high, data chosen per beat.
  task automatic run_vec(input vec_t v, input int idx);
    int    beats;
    bit    got;
    string t;
    t = $sformatf("v%0d", idx);
    mem_resp = 1'b1;
    mem_rdata = '0;
    issue(v.sel, v.wr, v.f3, v.addr, v.wdata, t);
    beats = 0;
    got = 1'b0;
    for (int c = 1; c <= 10 && !got; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (o_rd || o_wr) begin
        check({t, "_dir"}, o_wr, v.wr);
        if (beats == 0) begin
          check({t, "_addr0"}, o_addr, v.a0);
          check({t, "_be0"}, o_be, v.be0);
          check({t, "_wdata0"}, o_wdata, v.wd0);
          mem_rdata = v.lo;
        end else begin
          check({t, "_addr1"}, o_addr, v.a1);
          check({t, "_be1"}, o_be, v.be1);
          check({t, "_wdata1"}, o_wdata, v.wd1);
          mem_rdata = v.hi;
        end
        beats++;
      end
      if (o_done) begin
        got = 1'b1;
        check({t, "_rdata"}, o_rdata, v.rdata);
        check({t, "_fault"}, o_fault, v.fault);
        check({t, "_cause"}, o_cause, v.cause);
        check({t, "_latency"}, c, v.lat);
      end
    end
    check({t, "_done_seen"}, got, 1'b1);
    check({t, "_beats"}, beats, v.beats);
    @(posedge clk);
  endtask

  // lw 0x100 with mem_resp low until cycle 4 (late) or never (timeout).
  task automatic run_timeout(input bit late, input logic [31:0] rd);
    int    rc;
    bit    got;
    string t;
    t = late ? "late_resp" : "timeout";
    mem_resp = 1'b0;
    mem_rdata = '0;
    issue(1'b0, 1'b0, 3'b010, 32'h100, 32'h0, t);
    rc = 0;
    got = 1'b0;
    for (int c = 1; c <= 12 && !got; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (o_rd) rc++;
      if (late && c == 4) begin mem_resp = 1'b1; mem_rdata = rd; end
      if (o_done) begin
        got = 1'b1;
        check({t, "_latency"}, c, 5);
        check({t, "_fault"}, o_fault, !late);
        check({t, "_cause"}, o_cause, late ? 2'd0 : 2'd2);
        check({t, "_rdata"}, o_rdata, late ? rd : 32'h0);
      end
    end
    check({t, "_done_seen"}, got, 1'b1);
    check({t, "_read_cycles"}, rc, 4);
    @(posedge clk);
    mem_resp = 1'b0;
  endtask

  initial begin
    //      sel wr f3      addr      wdata         lo            hi            nb a0       be0      wd0           a1       be1      wd1           rdata         fl c  lat
    vq.push_back(mk(0, 0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 32'h0,        1, 32'h100, 4'b1111, 32'h0,        32'h0,   4'b0000, 32'h0,        32'hDEADBEEF, 0, 0, 2));
    vq.push_back(mk(0, 0, 3'b001, 32'h103, 32'h0,        32'hAA112233, 32'h445566FF, 2, 32'h100, 4'b1000, 32'h0,        32'h104, 4'b0001, 32'h0,        32'hFFFFFFAA, 0, 0, 3));
    vq.push_back(mk(0, 1, 3'b010, 32'h102, 32'h11223344, 32'h0,        32'h0,        2, 32'h100, 4'b1100, 32'h33440000, 32'h104, 4'b0011, 32'h00001122, 32'h0,        0, 0, 3));
    vq.push_back(mk(0, 0, 3'b000, 32'h001, 32'h0,        32'h00008000, 32'h0,        1, 32'h000, 4'b0010, 32'h0,        32'h0,   4'b0000, 32'h0,        32'hFFFFFF80, 0, 0, 2));
    vq.push_back(mk(0, 0, 3'b101, 32'h202, 32'h0,        32'h9ABC0000, 32'h0,        1, 32'h200, 4'b1100, 32'h0,        32'h0,   4'b0000, 32'h0,        32'h00009ABC, 0, 0, 2));
    vq.push_back(mk(0, 1, 3'b000, 32'h201, 32'h000000A5, 32'h0,        32'h0,        1, 32'h200, 4'b0010, 32'h0000A500, 32'h0,   4'b0000, 32'h0,        32'h0,        0, 0, 2));
    vq.push_back(mk(0, 1, 3'b001, 32'h106, 32'h0000BEEF, 32'h0,        32'h0,        1, 32'h104, 4'b1100, 32'hBEEF0000, 32'h0,   4'b0000, 32'h0,        32'h0,        0, 0, 2));
    vq.push_back(mk(0, 0, 3'b001, 32'h101, 32'h0,        32'h00FF7F00, 32'h0,        1, 32'h100, 4'b0110, 32'h0,        32'h0,   4'b0000, 32'h0,        32'hFFFFFF7F, 0, 0, 2));
    vq.push_back(mk(0, 0, 3'b010, 32'h10A, 32'h0,        32'h11223344, 32'h55667788, 2, 32'h108, 4'b1100, 32'h0,        32'h10C, 4'b0011, 32'h0,        32'h77881122, 0, 0, 3));
    vq.push_back(mk(0, 0, 3'b111, 32'h100, 32'h0,        32'h0,        32'h0,        0, 32'h0,   4'b0000, 32'h0,        32'h0,   4'b0000, 32'h0,        32'h0,        1, 3, 1));
    vq.push_back(mk(0, 1, 3'b100, 32'h100, 32'h12,       32'h0,        32'h0,        0, 32'h0,   4'b0000, 32'h0,        32'h0,   4'b0000, 32'h0,        32'h0,        1, 3, 1));
    vq.push_back(mk(0, 0, 3'b011, 32'h100, 32'h0,        32'h0,        32'h0,        0, 32'h0,   4'b0000, 32'h0,        32'h0,   4'b0000, 32'h0,        32'h0,        1, 3, 1));
    vq.push_back(mk(0, 0, 3'b110, 32'h100, 32'h0,        32'h0,        32'h0,        0, 32'h0,   4'b0000, 32'h0,        32'h0,   4'b0000, 32'h0,        32'h0,        1, 3, 1));
    vq.push_back(mk(1, 0, 3'b010, 32'h101, 32'h0,        32'h0,        32'h0,        0, 32'h0,   4'b0000, 32'h0,        32'h0,   4'b0000, 32'h0,        32'h0,        1, 1, 1));
    vq.push_back(mk(1, 0, 3'b111, 32'h100, 32'h0,        32'h0,        32'h0,        0, 32'h0,   4'b0000, 32'h0,        32'h0,   4'b0000, 32'h0,        32'h0,        1, 3, 1));
    vq.push_back(mk(1, 0, 3'b010, 32'h104, 32'h0,        32'h01234567, 32'h0,        1, 32'h104, 4'b1111, 32'h0,        32'h0,   4'b0000, 32'h0,        32'h01234567, 0, 0, 2));
    vq.push_back(mk(1, 1, 3'b001, 32'h103, 32'h00001234, 32'h0,        32'h0,        0, 32'h0,   4'b0000, 32'h0,        32'h0,   4'b0000, 32'h0,        32'h0,        1, 1, 1));
    vq.push_back(mk(0, 0, 3'b100, 32'h003, 32'h0,        32'h80000000, 32'h0,        1, 32'h000, 4'b1000, 32'h0,        32'h0,   4'b0000, 32'h0,        32'h00000080, 0, 0, 2));

    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", o_ready, 1'b1);
    check("rst_mem_read", o_rd, 1'b0);
    check("rst_mem_write", o_wr, 1'b0);
    check("rst_be", o_be, 4'b0000);
    check("rst_mem_addr", o_addr, 32'h0);
    check("rst_mem_wdata", o_wdata, 32'h0);
    check("rst_done", o_done, 1'b0);
    check("rst_fault", o_fault, 1'b0);
    check("rst_cause", o_cause, 2'd0);
    check("rst_rdata", o_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) run_vec(vq[i], i);

    run_timeout(1'b0, 32'h0);
    run_timeout(1'b1, 32'h0BADF00D);

    // Reset during BEAT1 of a split store aborts without a done pulse.
    mem_resp = 1'b1;
    issue(1'b0, 1'b1, 3'b010, 32'h102, 32'h11223344, "abort");
    @(posedge clk); #1;
    check("abort_beat1_write", o_wr, 1'b1);
    check("abort_beat1_be", o_be, 4'b0011);
    #2 rst = 1'b1;
    #1;
    check("abort_write_drop", o_wr, 1'b0);
    check("abort_be_drop", o_be, 4'b0000);
    check("abort_ready", o_ready, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("abort_no_done%0d", k), o_done, 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check($sformatf("post_rst_no_done%0d", k), o_done, 1'b0);
    end
    run_vec(vq[17], 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
